// File: rtl/seg_scan_if.sv
// Bundle between the core-facing load port and the display pins of the
// segment scan scheduler.
//   value       : 32-bit word to show, nibble i on digit i
//   value_valid : load strobe for value
//   SEG         : cathodes {g,f,e,d,c,b,a}, active-low
//   AN          : anodes, active-low, one-hot-low while a digit is driven
//   digit_idx   : digit currently scheduled
//   frame_done  : one-cycle pulse after digit 7 finishes driving
//   pending     : a captured value waits for the next frame boundary
// master = value producer / pin observer, slave = the scheduler.
interface seg_scan_if;
  logic [31:0] value;
  logic        value_valid;
  logic [6:0]  SEG;
  logic [7:0]  AN;
  logic [2:0]  digit_idx;
  logic        frame_done;
  logic        pending;

  modport master (
    output value, value_valid,
    input  SEG, AN, digit_idx, frame_done, pending
  );

  modport slave (
    input  value, value_valid,
    output SEG, AN, digit_idx, frame_done, pending
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan scheduler for an 8-digit, common-cathode-bus
// 7-segment display. Shows a 32-bit word as 8 hex digits, blanks all anodes
// between digits to avoid ghosting, and only swaps in a new word at frame
// boundaries so one frame never mixes two values.
//
// Ports:
//   CLK  : board clock
//   RST  : synchronous reset, active-low
//   bus  : seg_scan_if.slave (value/value_valid in, SEG/AN/digit_idx/
//          frame_done/pending out; all outputs registered)
//
// Parameters:
//   DIGIT_TICKS : cycles each digit is driven (>=1)
//   BLANK_TICKS : cycles all anodes are off before each digit (>=1)
//   CNT_W       : tick counter width, holds max(DIGIT_TICKS,BLANK_TICKS)-1
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is always shown).
module seg_scan_ctrl #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000,
  parameter int CNT_W       = 17
) (
  input  logic       CLK,
  input  logic       RST,
  seg_scan_if.slave  bus
);

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             boundary;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             fdone_q;
  logic [3:0]       nibble;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // True when digit i and every higher digit are zero; digit 0 never blanks.
  function automatic logic lz_blank(input logic [31:0] s, input logic [2:0] i);
    return (i != 3'd0) && ((s >> {i, 2'b00}) == 32'd0);
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    boundary   = 1'b0;
    an_d       = 8'hFF;
    seg_d      = 7'h7F;
    nibble     = 4'h0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == DIGIT_LAST) begin
          state_d  = ST_BLANK;
          cnt_d    = '0;
          idx_d    = idx_q + 3'd1;
          boundary = (idx_q == 3'd7);
        end
      end
    endcase

    // A strobe on the boundary cycle bypasses the pending register so the
    // word is shown from digit 0 of the frame that starts next.
    if (boundary) begin
      if (bus.value_valid) begin
        shadow_d = bus.value;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        shadow_d = pend_val_q;
        pend_d   = 1'b0;
      end
    end else if (bus.value_valid) begin
      pend_val_d = bus.value;
      pend_d     = 1'b1;
    end

    // Outputs are computed from next-state values and registered, so the
    // anode and its segments always change on the same edge.
    nibble = shadow_d[{idx_d, 2'b00} +: 4];
    if (state_d == ST_DRIVE) begin
      an_d  = ~(8'b1 << idx_d);
      seg_d = seg_decode(nibble);
`ifdef LEADING_ZERO_BLANK_EN
      if (lz_blank(shadow_d, idx_d)) seg_d = 7'h7F;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shadow_q   <= 32'd0;
      pend_val_q <= 32'd0;
      pend_q     <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      fdone_q    <= boundary;
    end
  end

  assign bus.SEG        = seg_q;
  assign bus.AN         = an_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = fdone_q;
  assign bus.pending    = pend_q;

endmodule
